// File: rtl/video_pattern_gen_if.sv
// Raster-in / pixel-out bundle between the timing controller, the pattern generator and the TX.
// The generator takes the slave view; whatever drives the raster takes the master view.
interface video_pattern_gen_if #(
  parameter int unsigned HCNTR_BITS = 11,
  parameter int unsigned VCNTR_BITS = 10,
  parameter int unsigned FC_BITS    = 6
);
  logic [HCNTR_BITS-1:0] hcount_i;
  logic [VCNTR_BITS-1:0] vcount_i;
  logic                  hs_i;
  logic                  vs_i;
  logic                  ad_i;
  logic                  nf_i;
  logic [FC_BITS-1:0]    fc_i;
  logic [1:0]            mode_i;
  logic [23:0]           solid_rgb_i;
  logic [23:0]           rgb_o;
  logic                  de_o;
  logic                  hs_o;
  logic                  vs_o;
  logic                  sof_o;
  logic [1:0]            mode_o;

  modport slave (
    input  hcount_i, vcount_i, hs_i, vs_i, ad_i, nf_i, fc_i, mode_i, solid_rgb_i,
    output rgb_o, de_o, hs_o, vs_o, sof_o, mode_o
  );

  modport master (
    output hcount_i, vcount_i, hs_i, vs_i, ad_i, nf_i, fc_i, mode_i, solid_rgb_i,
    input  rgb_o, de_o, hs_o, vs_o, sof_o, mode_o
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Two-stage test-pattern source: solid, colour bars, checkerboard, scrolling gradient.
// Mode and solid colour are latched on the new-frame pulse so frames are never torn.
module video_pattern_gen #(
  parameter int unsigned ACTIVE_H_PIXELS = 1280,
  parameter int unsigned ACTIVE_LINES    = 720,
  parameter int unsigned HCNTR_BITS      = 11,
  parameter int unsigned VCNTR_BITS      = 10,
  parameter int unsigned FC_BITS         = 6,
  parameter int unsigned CHK_LOG2        = 5,
  parameter int unsigned DEFAULT_MODE    = 1
) (
  input logic                pixel_clk_i,
  input logic                rst_n_i,
  video_pattern_gen_if.slave vid
);

  localparam int unsigned BarW    = ACTIVE_H_PIXELS / 8;
  localparam int unsigned ColBits = $clog2(BarW + 1);

  typedef enum logic [1:0] {ModeSolid, ModeBars, ModeChecker, ModeGradient} mode_e;

  mode_e       mode_q;
  logic [23:0] solid_q;

  // Running bar position for the pixel after the current one; replaces a divider.
  logic [2:0]         bar_run_q, bar_run_d, bar_cur;
  logic [ColBits-1:0] col_run_q, col_run_d, col_cur;

  // Stage 1
  logic [HCNTR_BITS-1:0] hcount_s1;
  logic [VCNTR_BITS-1:0] vcount_s1;
  logic [FC_BITS-1:0]    fc_s1;
  logic                  hs_s1, vs_s1, ad_s1;
  logic [2:0]            bar_s1;

  // Stage 2
  logic [23:0] rgb_q;
  logic        de_q, hs_q, vs_q, sof_q;

  logic [23:0]        pix_rgb;
  logic [FC_BITS+1:0] fc_x4;
  logic [7:0]         grad_off;
  logic               in_range;

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    logic [23:0] c;
    case (bar)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  always_comb begin
    if (vid.hcount_i == '0) begin
      bar_cur = '0;
      col_cur = '0;
    end else begin
      bar_cur = bar_run_q;
      col_cur = col_run_q;
    end
    bar_run_d = bar_cur;
    col_run_d = col_cur;
    // Saturate in bar 7 so remainder and blanking pixels stay there.
    if (bar_cur != 3'd7) begin
      if (col_cur == ColBits'(BarW - 1)) begin
        bar_run_d = bar_cur + 3'd1;
        col_run_d = '0;
      end else begin
        col_run_d = col_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q  <= mode_e'(DEFAULT_MODE);
      solid_q <= '0;
    end else if (vid.nf_i) begin
      mode_q  <= mode_e'(vid.mode_i);
      solid_q <= vid.solid_rgb_i;
    end
  end

  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bar_run_q <= '0;
      col_run_q <= '0;
      hcount_s1 <= '0;
      vcount_s1 <= '0;
      fc_s1     <= '0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
      ad_s1     <= 1'b0;
      bar_s1    <= '0;
    end else begin
      bar_run_q <= bar_run_d;
      col_run_q <= col_run_d;
      hcount_s1 <= vid.hcount_i;
      vcount_s1 <= vid.vcount_i;
      fc_s1     <= vid.fc_i;
      hs_s1     <= vid.hs_i;
      vs_s1     <= vid.vs_i;
      ad_s1     <= vid.ad_i;
      bar_s1    <= bar_cur;
    end
  end

  assign fc_x4    = {fc_s1, 2'b00};
  assign grad_off = 8'(fc_x4);
  assign in_range = (hcount_s1 < HCNTR_BITS'(ACTIVE_H_PIXELS)) &&
                    (vcount_s1 < VCNTR_BITS'(ACTIVE_LINES));

  always_comb begin
    pix_rgb = '0;
    unique case (mode_q)
      ModeSolid:    pix_rgb = solid_q;
      ModeBars:     pix_rgb = bar_colour(bar_s1);
      ModeChecker:  pix_rgb = (hcount_s1[CHK_LOG2] ^ vcount_s1[CHK_LOG2]) ? 24'hFFFFFF : 24'h0;
      ModeGradient: pix_rgb = {hcount_s1[7:0] + grad_off, vcount_s1[7:0], grad_off};
    endcase
  end

  always_ff @(posedge pixel_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      sof_q <= 1'b0;
    end else begin
      rgb_q <= (ad_s1 && in_range) ? pix_rgb : 24'h0;
      de_q  <= ad_s1;
      hs_q  <= hs_s1;
      vs_q  <= vs_s1;
      sof_q <= ad_s1 && (hcount_s1 == '0) && (vcount_s1 == '0);
    end
  end

  assign vid.rgb_o  = rgb_q;
  assign vid.de_o   = de_q;
  assign vid.hs_o   = hs_q;
  assign vid.vs_o   = vs_q;
  assign vid.sof_o  = sof_q;
  assign vid.mode_o = mode_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: raster driver pushes expected pixels, a monitor checks them
// against the outputs exactly two pixel clocks later.
module tb_video_pattern_gen;

  localparam int HTot = 1344;

  typedef struct {
    logic [23:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        sof;
    int          due;
    int          h;
    int          v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_pattern_gen_if #(.HCNTR_BITS(11), .VCNTR_BITS(10), .FC_BITS(6)) vif ();

  video_pattern_gen #(
    .ACTIVE_H_PIXELS(1280),
    .ACTIVE_LINES   (720),
    .HCNTR_BITS     (11),
    .VCNTR_BITS     (10),
    .FC_BITS        (6),
    .CHK_LOG2       (5),
    .DEFAULT_MODE   (1)
  ) dut (
    .pixel_clk_i(clk),
    .rst_n_i    (rst_n),
    .vid        (vif)
  );

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [1:0]  m_mode = 2'd1;
  logic [23:0] m_solid = 24'h0;
  logic [1:0]  req_mode = 2'd1;
  logic [23:0] req_solid = 24'h0;
  bit          nf_prev = 1'b0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic [23:0] pattern(input int h, input int v, input int fcv,
                                          input logic [1:0] md, input logic [23:0] sol);
    int bar;
    int off;
    case (md)
      2'd0: return sol;
      2'd1: begin
        bar = h / 160;
        if (bar > 7) bar = 7;
        return bars[bar];
      end
      2'd2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: begin
        off = (fcv * 4) % 256;
        return {8'((h + off) % 256), 8'(v % 256), 8'(off)};
      end
    endcase
  endfunction

  // Monitor: compare every entry whose due edge has just passed.
  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if ({vif.rgb_o, vif.de_o, vif.hs_o, vif.vs_o, vif.sof_o} !==
          {e.rgb, e.de, e.hs, e.vs, e.sof} || e.due != cyc) begin
        errors++;
        $display("FAIL pix h=%0d v=%0d got rgb=%h de=%b hs=%b vs=%b sof=%b want rgb=%h de=%b hs=%b vs=%b sof=%b",
                 e.h, e.v, vif.rgb_o, vif.de_o, vif.hs_o, vif.vs_o, vif.sof_o,
                 e.rgb, e.de, e.hs, e.vs, e.sof);
      end
    end
  end

  task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit nf,
                       input int fcv, input bit rel);
    exp_t e;
    bit   ad;
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    if (nf_prev) check("mode_o_after_nf", 32'(vif.mode_o), 32'(m_mode));
    ad = (h < 1280) && (v < 720);
    vif.hcount_i    = 11'(h);
    vif.vcount_i    = 10'(v);
    vif.hs_i        = hs;
    vif.vs_i        = vs;
    vif.ad_i        = ad;
    vif.nf_i        = nf;
    vif.fc_i        = 6'(fcv);
    vif.mode_i      = req_mode;
    vif.solid_rgb_i = req_solid;
    if (nf && rst_n) begin
      m_mode  = req_mode;
      m_solid = req_solid;
    end
    nf_prev = nf && rst_n;
    e.due = cyc + 2;
    e.h   = h;
    e.v   = v;
    if (rst_n) begin
      e.rgb = ad ? pattern(h, v, fcv, m_mode, m_solid) : 24'h0;
      e.de  = ad;
      e.hs  = hs;
      e.vs  = vs;
      e.sof = ad && h == 0 && v == 0;
    end else begin
      e.rgb = '0; e.de = 0; e.hs = 0; e.vs = 0; e.sof = 0;
    end
    sb.push_back(e);
  endtask

  task automatic line(input int v, input bit vsl, input bit nfl, input int fcv, input bit do_rst);
    for (int h = 0; h < HTot; h++) begin
      bit hs_v;
      bit nf_v;
      bit rel_v;
      hs_v  = (h >= 1296) && (h < 1336);
      nf_v  = (nfl && h == 1300) || (do_rst && h == 1299);
      rel_v = do_rst && h == 1300;
      if (do_rst && h == 600) begin
        @(posedge clk);
        #3;
        rst_n   = 1'b0;
        m_mode  = 2'd1;
        m_solid = 24'h0;
        // Everything still in flight lands while reset is held, so it must read as zero.
        for (int i = 0; i < sb.size(); i++) begin
          exp_t t;
          t = sb[i];
          t.rgb = '0; t.de = 0; t.hs = 0; t.vs = 0; t.sof = 0;
          sb[i] = t;
        end
        #1;
        check("async_rst_rgb", 32'(vif.rgb_o), 32'h0);
        check("async_rst_flags", 32'({vif.de_o, vif.hs_o, vif.vs_o, vif.sof_o}), 32'h0);
        check("async_rst_mode", 32'(vif.mode_o), 32'd1);
      end
      drive(h, v, hs_v, vsl, nf_v, fcv, rel_v);
    end
    check("mode_o_hold", 32'(vif.mode_o), 32'(m_mode));
  endtask

  initial begin
    vif.hcount_i = '0; vif.vcount_i = '0; vif.hs_i = 0; vif.vs_i = 0; vif.ad_i = 0;
    vif.nf_i = 0; vif.fc_i = '0; vif.mode_i = 2'd1; vif.solid_rgb_i = '0;
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(vif.rgb_o), 32'h0);
    check("reset_flags", 32'({vif.de_o, vif.hs_o, vif.vs_o, vif.sof_o}), 32'h0);
    check("reset_mode", 32'(vif.mode_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Colour bars, then a mid-frame request that must wait for the next nf.
    line(749, 0, 1, 0, 0);
    line(0, 0, 0, 0, 0);
    req_mode  = 2'd0;
    req_solid = 24'h123456;
    line(1, 0, 0, 0, 0);
    for (int v = 720; v < 725; v++) line(v, 1, 0, 0, 0);
    line(725, 0, 1, 0, 0);

    // Solid; a toggle without nf must not take effect.
    line(0, 0, 0, 0, 0);
    line(1, 0, 0, 0, 0);
    req_mode = 2'd2;
    line(2, 0, 0, 0, 0);
    line(726, 0, 1, 0, 0);

    // Checkerboard.
    line(0, 0, 0, 0, 0);
    line(31, 0, 0, 0, 0);
    line(32, 0, 0, 0, 0);

    // Gradient with two frame counters, plus a line beyond the active area.
    req_mode = 2'd3;
    line(740, 0, 1, 3, 0);
    line(5, 0, 0, 3, 0);
    line(741, 0, 1, 63, 0);
    line(300, 0, 0, 63, 0);
    line(720, 0, 0, 63, 0);

    // Random frames with ignored mid-frame request changes.
    for (int f = 0; f < 4; f++) begin
      int fcr;
      fcr       = int'($urandom_range(0, 63));
      req_mode  = 2'($urandom_range(0, 3));
      req_solid = 24'($urandom);
      line(742, 0, 1, fcr, 0);
      req_mode  = 2'($urandom_range(0, 3));
      req_solid = 24'($urandom);
      line(int'($urandom_range(0, 719)), 0, 0, fcr, 0);
      line(int'($urandom_range(0, 719)), 0, 0, fcr, 0);
    end

    // Reset mid-line; an nf while reset is held must be ignored.
    req_mode = 2'd1;
    line(743, 0, 1, 0, 0);
    req_mode = 2'd3;
    line(10, 0, 0, 0, 1);
    line(0, 0, 0, 0, 0);
    line(1, 0, 0, 0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
